// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt dispatcher: FSM state encoding,
// source count, vector width and the default ack timeout.
package irq_pkg;

    localparam int N_SRC       = 8;
    localparam int VEC_W       = 3;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

endpackage

// File: rtl/irq_vec_decode.sv
// Converts a 3-bit source index into the 8-bit one-hot acknowledge pattern.
module irq_vec_decode
    import irq_pkg::*;
(
    input  logic [VEC_W-1:0] i_idx,
    output logic [N_SRC-1:0] o_onehot
);

    // Set exactly the bit addressed by the index.
    always_comb begin
        o_onehot        = '0;
        o_onehot[i_idx] = 1'b1;
    end

endmodule

// File: rtl/irq_dispatcher.sv
// Interrupt dispatcher: qualifies the encoded request against int_en and the
// per-source mask, raises irq with a latched vector, and returns a one-hot
// acknowledge to the serviced source once the CPU accepts.
//
// Optional feature: define IRQ_TIMEOUT_EN to abandon an unacknowledged irq
// after TIMEOUT cycles in ASSERT and raise the sticky timeout_err flag.
//
// Handshake: a request is taken in IDLE when req_valid=1, status[7]=1 and the
// source is unmasked; irq then stays high until the cycle cpu_ack=1 is seen
// (or the timeout expires), and src_ack pulses one cycle after that ack.
module irq_dispatcher
    import irq_pkg::*;
#(
    parameter int N_SRC   = irq_pkg::N_SRC,
    parameter int TIMEOUT = irq_pkg::TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic [VEC_W-1:0] code,
    input  logic             req_valid,
    input  logic [7:0]       status,
    input  logic             mask_wr,
    input  logic [N_SRC-1:0] mask_data,
    input  logic             cpu_ack,
    input  logic             err_clr,
    output logic             irq,
    output logic [VEC_W-1:0] vector,
    output logic [N_SRC-1:0] src_ack,
    output logic             busy,
    output logic             timeout_err,
    output state_t           o_dbg_state
);

    if (N_SRC != 8) begin : g_bad_nsrc
        $error("irq_dispatcher: N_SRC must be 8");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("irq_dispatcher: TIMEOUT must be 1..255");
    end

    state_t           r_state;
    logic [VEC_W-1:0] r_vector;
    logic             r_irq;
    logic [N_SRC-1:0] r_src_ack;
    logic             r_busy;
    logic [N_SRC-1:0] r_mask;
    logic [N_SRC-1:0] w_onehot;
    logic             w_take;
    logic             w_unused;

`ifdef IRQ_TIMEOUT_EN
    // Last counter value before the timeout fires: irq is then high for
    // exactly TIMEOUT cycles when no ack arrives.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] r_cnt;
    logic       r_timeout_err;
    assign timeout_err = r_timeout_err;
    assign w_unused    = ^status[6:0];
`else
    assign timeout_err = 1'b0;
    assign w_unused    = ^{status[6:0], err_clr};
`endif

    irq_vec_decode u_decode (
        .i_idx    (r_vector),
        .o_onehot (w_onehot)
    );

    // Capture qualifier; uses the mask as it stood before any same-cycle write.
    assign w_take = req_valid && status[7] && !r_mask[code];

    // Dispatcher FSM with registered irq/src_ack/busy, mask and error flag.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state       <= ST_IDLE;
            r_vector      <= '0;
            r_irq         <= 1'b0;
            r_src_ack     <= '0;
            r_busy        <= 1'b0;
            r_mask        <= '0;
`ifdef IRQ_TIMEOUT_EN
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            if (mask_wr) begin
                r_mask <= mask_data;
            end
            r_src_ack <= '0;
`ifdef IRQ_TIMEOUT_EN
            // A timeout set later in this block overrides the clear.
            if (err_clr) begin
                r_timeout_err <= 1'b0;
            end
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_state  <= ST_ASSERT;
                        r_vector <= code;
                        r_irq    <= 1'b1;
                        r_busy   <= 1'b1;
`ifdef IRQ_TIMEOUT_EN
                        r_cnt    <= '0;
`endif
                    end
                end
                ST_ASSERT: begin
                    // Ack beats timeout when both land on the same cycle.
                    if (cpu_ack) begin
                        r_state   <= ST_SERVICE;
                        r_irq     <= 1'b0;
                        r_src_ack <= w_onehot;
                    end
`ifdef IRQ_TIMEOUT_EN
                    else if (r_cnt == TO_LAST) begin
                        r_state       <= ST_IDLE;
                        r_irq         <= 1'b0;
                        r_busy        <= 1'b0;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
`endif
                end
                ST_SERVICE: begin
                    r_state <= ST_HOLDOFF;
                end
                ST_HOLDOFF: begin
                    // One quiet cycle so the source can drop its line.
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_irq   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign irq         = r_irq;
    assign vector      = r_vector;
    assign src_ack     = r_src_ack;
    assign busy        = r_busy;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_irq_dispatcher.sv
// Self-checking bench for irq_dispatcher. Expected src_ack pulses are queued
// when the ack is driven and compared when the DUT pulses; other outputs are
// compared directly after each clock edge.
module tb_irq_dispatcher;
    import irq_pkg::*;

`ifdef IRQ_TIMEOUT_EN
    localparam int TB_TO = 4;
`else
    localparam int TB_TO = 15;
`endif

    logic       clk;
    logic       rstN;
    logic [2:0] code;
    logic       req_valid;
    logic [7:0] status;
    logic       mask_wr;
    logic [7:0] mask_data;
    logic       cpu_ack;
    logic       err_clr;
    logic       irq;
    logic [2:0] vector;
    logic [7:0] src_ack;
    logic       busy;
    logic       timeout_err;
    state_t     dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    irq_dispatcher #(.N_SRC(8), .TIMEOUT(TB_TO)) dut (
        .clk         (clk),
        .rstN        (rstN),
        .code        (code),
        .req_valid   (req_valid),
        .status      (status),
        .mask_wr     (mask_wr),
        .mask_data   (mask_data),
        .cpu_ack     (cpu_ack),
        .err_clr     (err_clr),
        .irq         (irq),
        .vector      (vector),
        .src_ack     (src_ack),
        .busy        (busy),
        .timeout_err (timeout_err),
        .o_dbg_state (dbg_state)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mask(input logic [7:0] m);
        mask_wr   = 1'b1;
        mask_data = m;
        tick();
        mask_wr   = 1'b0;
    endtask

    // Ack the pending irq and walk through SERVICE/HOLDOFF back to IDLE.
    task automatic ack_and_finish(input logic [7:0] exp_ack, input string tag);
        exp_q.push_back(exp_ack);
        req_valid = 1'b0;
        cpu_ack   = 1'b1;
        tick();
        cpu_ack   = 1'b0;
        chk({tag, "_irq_in_service"}, irq, 0);
        chk({tag, "_busy_in_service"}, busy, 1);
        tick();
        chk({tag, "_src_ack_holdoff"}, src_ack, 0);
        tick();
        chk({tag, "_busy_idle"}, busy, 0);
    endtask

    // Scoreboard monitor: every src_ack pulse must match the queue head.
    always @(negedge clk) begin
        if (src_ack !== 8'h00) begin
            if (exp_q.size() == 0) chk("src_ack_unexpected", src_ack, 8'h00);
            else                   chk("src_ack", src_ack, exp_q.pop_front());
        end
    end

    initial begin
        rstN = 1'b1; code = 3'd0; req_valid = 1'b0; status = 8'h00;
        mask_wr = 1'b0; mask_data = 8'h00; cpu_ack = 1'b0; err_clr = 1'b0;
        #3 rstN = 1'b0;
        #1;
        chk("rst_irq", irq, 0);
        chk("rst_busy", busy, 0);
        chk("rst_vector", vector, 0);
        chk("rst_src_ack", src_ack, 0);
        chk("rst_timeout_err", timeout_err, 0);
        tick(); tick();
        rstN = 1'b1;
        tick();
        chk("post_rst_irq", irq, 0);

        // Basic dispatch of source 5.
        code = 3'd5; req_valid = 1'b1; status = 8'h80;
        tick();
        chk("t1_irq", irq, 1);
        chk("t1_vector", vector, 5);
        chk("t1_busy", busy, 1);
        ack_and_finish(8'h20, "t1");

        // int_en low: never captured.
        code = 3'd2; req_valid = 1'b1; status = 8'h00;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t2_irq_disabled", irq, 0);
        end
        req_valid = 1'b0;

        // Masked source 3 ignored, source 4 taken.
        write_mask(8'h08);
        status = 8'h80; code = 3'd3; req_valid = 1'b1;
        tick(); tick();
        chk("t3_masked_irq", irq, 0);
        chk("t3_masked_busy", busy, 0);
        code = 3'd4;
        tick();
        chk("t3_irq", irq, 1);
        chk("t3_vector", vector, 4);
        ack_and_finish(8'h10, "t3");

        // Mask write coinciding with a capture uses the old mask.
        code = 3'd2; req_valid = 1'b1; mask_wr = 1'b1; mask_data = 8'h04;
        tick();
        mask_wr = 1'b0;
        chk("t4_same_cycle_irq", irq, 1);
        chk("t4_same_cycle_vector", vector, 2);
        ack_and_finish(8'h04, "t4");
        code = 3'd2; req_valid = 1'b1;
        tick(); tick();
        chk("t4_new_mask_irq", irq, 0);
        req_valid = 1'b0;

        // Vector holds while code/int_en/mask change during ASSERT.
        write_mask(8'h00);
        code = 3'd6; req_valid = 1'b1; status = 8'h80;
        tick();
        chk("t5_irq", irq, 1);
        code = 3'd7; status = 8'h00; mask_wr = 1'b1; mask_data = 8'h40;
        tick();
        mask_wr = 1'b0;
        chk("t5_hold_irq", irq, 1);
        chk("t5_hold_vector", vector, 6);
        tick();
        chk("t5_hold_irq2", irq, 1);
        chk("t5_hold_vector2", vector, 6);
        ack_and_finish(8'h40, "t5");
        write_mask(8'h00);
        status = 8'h80;

        // cpu_ack in IDLE does nothing.
        cpu_ack = 1'b1;
        tick(); tick();
        cpu_ack = 1'b0;
        chk("t6_idle_ack_busy", busy, 0);

`ifdef IRQ_TIMEOUT_EN
        // Unacknowledged irq times out after TIMEOUT cycles.
        code = 3'd1; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < TB_TO - 1; i++) begin
            chk("t7_irq_wait", irq, 1);
            tick();
        end
        chk("t7_irq_last", irq, 1);
        tick();
        chk("t7_irq_dropped", irq, 0);
        chk("t7_busy", busy, 0);
        chk("t7_timeout_err", timeout_err, 1);
        chk("t7_src_ack", src_ack, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t7_err_clr", timeout_err, 0);

        // Timeout coinciding with err_clr: flag stays set.
        code = 3'd3; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < TB_TO - 1; i++) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t8_err_wins", timeout_err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Ack on the timeout cycle wins.
        code = 3'd7; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < TB_TO - 1; i++) tick();
        ack_and_finish(8'h80, "t9");
        chk("t9_no_err", timeout_err, 0);
`else
        // Without timeout, irq waits indefinitely.
        code = 3'd1; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        chk("t7_irq_still", irq, 1);
        chk("t7_no_err", timeout_err, 0);
        ack_and_finish(8'h02, "t7");
`endif

        // Reset during ASSERT aborts the irq without src_ack.
        code = 3'd3; req_valid = 1'b1; status = 8'h80;
        tick();
        chk("t10_irq", irq, 1);
        req_valid = 1'b0;
        #2 rstN = 1'b0;
        #1;
        chk("t10_rst_irq", irq, 0);
        chk("t10_rst_busy", busy, 0);
        chk("t10_rst_vector", vector, 0);
        tick(); tick();
        rstN = 1'b1;
        tick(); tick();
        chk("t10_after_irq", irq, 0);
        chk("t10_after_src_ack", src_ack, 0);

        chk("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/irq_dispatcher.md
IRQ_DISPATCHER -- requirements
Module: irq_dispatcher

Interface
REQ-001 The block SHALL have parameter N_SRC, default 8, meaning the number of interrupt sources, fixed at 8 in this revision.
REQ-002 The block SHALL have parameter TIMEOUT, default 15, meaning the number of cycles irq waits for cpu_ack; legal range is 1-255.
REQ-003 Port clk SHALL be an input, 1 bit: the clock; all logic is rising-edge.
REQ-004 Port rstN SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-005 Port code SHALL be an input, 3 bits: the encoded highest-priority source index from the 8-to-3 priority encoder.
REQ-006 Port req_valid SHALL be an input, 1 bit: at least one source line is high (qualifies code=0 versus no request).
REQ-007 Port status SHALL be an input, 8 bits: the status register byte; bit 7 is int_en.
REQ-008 Port mask_wr SHALL be an input, 1 bit; port mask_data SHALL be an input, 8 bits: write strobe and data for the per-source mask register.
REQ-009 Port cpu_ack SHALL be an input, 1 bit: the CPU accepts the pending interrupt.
REQ-010 Port err_clr SHALL be an input, 1 bit: clears timeout_err.
REQ-011 Port irq SHALL be an output, 1 bit: interrupt request to the CPU.
REQ-012 Port vector SHALL be an output, 3 bits: the latched source index, valid while irq=1.
REQ-013 Port src_ack SHALL be an output, 8 bits: a one-hot acknowledge pulse returned to the serviced source.
REQ-014 Port busy SHALL be an output, 1 bit: the FSM is not IDLE.
REQ-015 Port timeout_err SHALL be an output, 1 bit: sticky timeout flag.

Function
REQ-016 The FSM SHALL have the states IDLE, ASSERT, SERVICE and HOLDOFF.
REQ-017 In IDLE, the FSM SHALL capture code into vector and go to ASSERT on the next edge when req_valid=1, status[7]=1 and mask[code]=0; otherwise it SHALL stay in IDLE.
REQ-018 irq SHALL be registered and equal 1 exactly while in ASSERT, so irq rises 1 cycle after the qualifying request.
REQ-019 vector SHALL hold constant from entry into ASSERT until return to IDLE; code changes during that time SHALL be ignored.
REQ-020 In ASSERT, cpu_ack=1 SHALL move the FSM to SERVICE on the next edge.
REQ-021 In SERVICE, src_ack SHALL equal the one-hot decode of vector for exactly 1 cycle, and the FSM SHALL then go to HOLDOFF.
REQ-022 src_ack SHALL be all zeros in every state other than SERVICE.
REQ-023 HOLDOFF SHALL last 1 cycle and then go to IDLE; the source deassertion is allowed to propagate during it, so no re-capture occurs in HOLDOFF.
REQ-024 cpu_ack SHALL be ignored in IDLE, SERVICE and HOLDOFF.
REQ-025 int_en falling, or mask[vector] being set, while in ASSERT SHALL NOT cancel the pending irq.
REQ-026 A mask_wr write SHALL update the mask on the edge where mask_wr=1 and take effect for capture decisions from the next cycle.
REQ-027 The mask write SHALL occur when mask_wr coincides with a capture, and that capture SHALL use the old mask.
REQ-028 When err_clr and a new timeout occur in the same cycle, the timeout SHALL win and timeout_err SHALL remain 1.

Reset
REQ-029 While rstN=0, the block SHALL force state=IDLE, vector=0, irq=0, src_ack=0, busy=0, timeout_err=0, mask=8'h00 and the timeout counter=0, asynchronously.
REQ-030 Reset asserted mid-operation SHALL abort any pending irq with no src_ack pulse.
REQ-031 Release of rstN SHALL take effect at the next clk edge.

Configuration
REQ-032 With IRQ_TIMEOUT_EN defined, an 8-bit counter SHALL count cycles in ASSERT.
REQ-033 With IRQ_TIMEOUT_EN defined, when the counter reaches TIMEOUT without cpu_ack, the FSM SHALL go to IDLE, drop irq, skip src_ack, and set timeout_err until err_clr.
REQ-034 With IRQ_TIMEOUT_EN defined, the counter SHALL clear on every ASSERT entry.
REQ-035 With IRQ_TIMEOUT_EN defined, cpu_ack on the same cycle the counter reaches TIMEOUT SHALL take priority, and the FSM SHALL go to SERVICE.
REQ-036 With IRQ_TIMEOUT_EN undefined, ASSERT SHALL wait indefinitely, timeout_err SHALL be tied to 0, and no counter SHALL be present.

Structure
REQ-037 Package irq_pkg SHALL hold the state enum typedef, N_SRC, VEC_W=3 and the default TIMEOUT.
REQ-038 A single sub-module irq_vec_decode SHALL convert the 3-bit index to an 8-bit one-hot value and be used for src_ack.

Verification
REQ-039 The bench SHALL check: code=5, req_valid=1, status=8'h80, mask=0 -> irq=1 and vector=5 the next cycle; cpu_ack -> src_ack=8'h20 for 1 cycle, then busy=0 after HOLDOFF.
REQ-040 The bench SHALL check: status=8'h00 with a valid request -> irq stays 0 for 20 cycles.
REQ-041 The bench SHALL check: mask_data=8'h08 written, then code=3 -> no irq; then code=4 -> irq with vector=4.
REQ-042 The bench SHALL check: irq pending, code changed to 7 and status[7] cleared -> vector stays at its original value and irq stays 1 until cpu_ack.
REQ-043 The bench SHALL check: with IRQ_TIMEOUT_EN and TIMEOUT=4, no cpu_ack -> irq drops after 4 cycles, timeout_err=1 and src_ack=0; err_clr -> timeout_err=0.
REQ-044 The bench SHALL check: rstN pulsed low while in ASSERT -> irq=0 and busy=0 immediately, with no src_ack pulse.
